// File: rtl/sram_bank.sv
// Single-port SRAM with byte enables, registered read + valid strobe, and a post-reset clear sweep.
// Optional per-byte even parity with error injection under SRAM_BANK_PARITY_EN.
module sram_bank #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
`ifdef SRAM_BANK_PARITY_EN
  input  logic            err_inj,
  output logic            perr,
`endif
  output logic            ready,
  output logic            rvalid,
  output logic [DW-1:0]   rdata,
  output logic            init_done
);

  localparam int NB = DW / 8;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          in_range;
  logic          acc;
  logic          wr_en;
  logic          rd_en;

  assign in_range  = ({1'b0, addr} < DEPTH_X);
  assign acc       = (state == S_READY) && req;
  assign wr_en     = acc && we && in_range;
  assign rd_en     = acc && !we;
  assign ready     = (state == S_READY);
  assign init_done = (state == S_READY);

  // Array has no reset; only the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef SRAM_BANK_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          mism;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        par_mem[cnt] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) par_mem[addr][i] <= (^wdata[8*i +: 8]) ^ err_inj;
        end
      end
    end
  end

  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < NB; i++) begin
      mism = mism | ((^mem[addr][8*i +: 8]) != par_mem[addr][i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr <= 1'b0;
    else     perr <= rd_en && in_range && mism;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_CLEAR;
      cnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (state == S_CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) state <= S_READY;
      end
      rvalid <= rd_en;
      if (rd_en) rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Directed checks of sram_bank: clear sweep, reads/writes, byte lanes, range, reset, parity.
module tb_sram_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        ready, rvalid, init_done;
  logic [15:0] rdata;
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [1:0]  be_b = 2'b00;
  logic [3:0]  addr_b = '0;
  logic [15:0] wdata_b = '0;
  logic        ready_b, rvalid_b, init_done_b;
  logic [15:0] rdata_b;
`ifdef SRAM_BANK_PARITY_EN
  logic        err_inj = 1'b0;
  logic        perr, perr_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_bank dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
`ifdef SRAM_BANK_PARITY_EN
    .err_inj(err_inj), .perr(perr),
`endif
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .init_done(init_done)
  );

  sram_bank #(.DW(16), .DEPTH(12), .AW(4)) dut12 (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .be(be_b), .addr(addr_b), .wdata(wdata_b),
`ifdef SRAM_BANK_PARITY_EN
    .err_inj(1'b0), .perr(perr_b),
`endif
    .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .init_done(init_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on instance a (b=0) or b (b=1); returns at the next negedge.
  task automatic op(input bit b, input logic w, input logic [1:0] e,
                    input logic [3:0] a, input logic [15:0] d);
    if (!b) begin req = 1'b1; we = w; be = e; addr = a; wdata = d; end
    else    begin req_b = 1'b1; we_b = w; be_b = e; addr_b = a; wdata_b = d; end
    @(negedge clk);
    req = 1'b0; req_b = 1'b0;
  endtask

  task automatic rd(input bit b, input logic [3:0] a, input logic [15:0] exp, input string tag);
    op(b, 1'b0, 2'b00, a, 16'h0);
    chk({tag, "_rvalid"}, b ? rvalid_b : rvalid, 1);
    chk({tag, "_rdata"},  b ? rdata_b : rdata, exp);
  endtask

  // Release reset at a negedge and check ready rises exactly 16 cycles later.
  task automatic release_and_clear(input string tag);
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk({tag, "_ready_low"}, ready, 0);
    end
    @(negedge clk);
    chk({tag, "_ready_high"}, ready, 1);
    chk({tag, "_init_done"}, init_done, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
`ifdef SRAM_BANK_PARITY_EN
    chk("rst_perr", perr, 0);
`endif
    release_and_clear("clr1");
    chk("b_ready_12", ready_b, 1);

    for (int a = 0; a < 16; a++) rd(0, 4'(a), 16'h0000, "clr_rd");
    @(negedge clk);
    chk("idle_rvalid", rvalid, 0);

    op(0, 1, 2'b11, 4'd0, 16'haaaa);
    op(0, 1, 2'b11, 4'd2, 16'h5678);
    op(0, 1, 2'b11, 4'd4, 16'hb4b3);
    op(0, 1, 2'b11, 4'd6, 16'hcccc);
    chk("wr_rvalid", rvalid, 0);
    rd(0, 4'd0, 16'haaaa, "rd0");
    rd(0, 4'd2, 16'h5678, "rd2");
    rd(0, 4'd4, 16'hb4b3, "rd4");
    rd(0, 4'd6, 16'hcccc, "rd6");
    rd(0, 4'd1, 16'h0000, "rd1");
    rd(0, 4'd5, 16'h0000, "rd5");
    @(negedge clk);
    chk("hold_rvalid", rvalid, 0);
    chk("hold_rdata", rdata, 16'h0000);

    op(0, 1, 2'b11, 4'd3, 16'hffff);
    op(0, 1, 2'b10, 4'd3, 16'h1200);
    rd(0, 4'd3, 16'h12ff, "be10");
    op(0, 1, 2'b00, 4'd3, 16'h0000);
    rd(0, 4'd3, 16'h12ff, "be00");
    op(0, 1, 2'b01, 4'd3, 16'h0034);
    rd(0, 4'd3, 16'h1234, "be01");

    op(1, 1, 2'b11, 4'd11, 16'h1111);
    op(1, 1, 2'b11, 4'd13, 16'hdead);
    rd(1, 4'd13, 16'h0000, "oor13");
    rd(1, 4'd12, 16'h0000, "oor12");
    rd(1, 4'd11, 16'h1111, "d12_w11");
    rd(1, 4'd1, 16'h0000, "d12_w1");
    rd(1, 4'd0, 16'h0000, "d12_w0");

`ifdef SRAM_BANK_PARITY_EN
    err_inj = 1'b1;
    op(0, 1, 2'b11, 4'd8, 16'h00ff);
    err_inj = 1'b0;
    rd(0, 4'd8, 16'h00ff, "par_inj");
    chk("par_inj_perr", perr, 1);
    @(negedge clk);
    chk("par_idle_perr", perr, 0);
    op(0, 1, 2'b11, 4'd8, 16'h00ff);
    rd(0, 4'd8, 16'h00ff, "par_ok");
    chk("par_ok_perr", perr, 0);
    rd(0, 4'd2, 16'h5678, "par_rd2");
    chk("par_rd2_perr", perr, 0);
`endif

    // Reset five cycles into a fresh clear sweep.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_clr_ready", ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_clr_rvalid", rvalid, 0);
    @(negedge clk);
    release_and_clear("clr2");
    rd(0, 4'd0, 16'h0000, "clr2_rd0");
    rd(0, 4'd3, 16'h0000, "clr2_rd3");

    // Reset with a read just sampled and its result pending.
    op(0, 1, 2'b11, 4'd2, 16'h5678);
    req = 1'b1; we = 1'b0; addr = 4'd2;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("pend_rvalid_pre", rvalid, 1);
    rst = 1'b1;
    #1;
    chk("pend_rvalid", rvalid, 0);
    chk("pend_rdata", rdata, 0);
    chk("pend_ready", ready, 0);
    @(negedge clk);
    chk("pend_rvalid_neg", rvalid, 0);
    release_and_clear("clr3");
    rd(0, 4'd2, 16'h0000, "clr3_rd2");
    rd(0, 4'd6, 16'h0000, "clr3_rd6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_bank.md
# sram_bank

Parametrised single-port synchronous SRAM with per-byte write enables, a registered read port with a valid strobe, and a hardware clear sequence that zeroes every word after reset. It is the next-generation data-memory block: it replaces the fixed 16×16 store with configurable width and depth, and it serves as the local data memory for datapath blocks and testbenches.

## Interface
- `DW`, 16, data width in bits; must be a multiple of 8.
- `DEPTH`, 16, number of words; any value from 2 to 2^`AW`.
- `AW`, 4, address width.
- `clk`  in  1  clock; all logic samples on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  1  access request; sampled only while `ready`=1.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `be`  in  `DW`/8  byte enables for writes; bit i covers `wdata[8i+7:8i]`; ignored on reads.
- `addr`  in  `AW`  word address.
- `wdata`  in  `DW`  write data.
- `ready`  out  1  block accepts requests.
- `rvalid`  out  1  one-cycle strobe; `rdata` holds the result of a read.
- `rdata`  out  `DW`  read data, registered.
- `init_done`  out  1  clear sequence finished; stays 1 until the next reset.

## Operation
- The FSM has two states: CLEAR and READY. `rst` forces CLEAR with the clear counter at 0.
- CLEAR:
  - Each cycle, write all-zero (all bytes) to address `counter`, then increment `counter`.
  - After writing `DEPTH`-1, go to READY.
  - `ready`=0 and `init_done`=0 throughout; `req` is ignored.
- READY:
  - `ready`=1 and `init_done`=1.
  - Write (`req`=1, `we`=1): each byte with `be[i]`=1 is updated; bytes with `be[i]`=0 are unchanged. `be`=0 is a legal no-op.
  - Read (`req`=1, `we`=0): the word at `addr` is registered into `rdata`, and `rvalid` pulses.
  - No read (idle or write): `rvalid`=0 and `rdata` holds its last value.
- Out-of-range address (`addr` ≥ `DEPTH`):
  - A write is dropped and the array is unchanged.
  - A read returns 0 with `rvalid`=1.
- One access per cycle; the port is single, so there is no collision case.

## Timing
- Reset values: `ready`=0, `init_done`=0, `rvalid`=0, `rdata`=0. With the parity macro, `perr`=0.
- Clear takes exactly `DEPTH` cycles after `rst` falls. `ready` rises on the edge after the last clear write, so with the default it is first high in cycle 16.
- Read latency is 1 cycle: a read sampled at edge N drives `rdata` and `rvalid`=1 after edge N, valid for one cycle.
- Write takes effect at the sampling edge. A read of the same address in the next cycle returns the new data.
- Back-to-back reads give `rvalid` high on consecutive cycles.
- `rst` asserted mid-clear or mid-read:
  - Outputs return to reset values immediately; the pending `rvalid` is lost.
  - Clear restarts from address 0 after `rst` falls.
- Memory contents are not reset directly; only the clear sequence zeroes them.

## Configuration
- Macro: `SRAM_BANK_PARITY_EN`.
- Defined:
  - One even-parity bit is stored per byte and written alongside it; the clear sequence writes parity 0.
  - Added ports: `err_inj` (in, 1), which inverts the stored parity of every byte written that cycle; and `perr` (out, 1).
  - On a read, `perr`=1 with `rvalid` if any byte's parity mismatches. `perr` is 0 whenever `rvalid`=0.
  - An out-of-range read gives `perr`=0.
- Undefined: no parity storage, and neither port exists.

## Test plan
- Reset release, defaults: `ready`=0 for 16 cycles, then 1; read all 16 addresses → `rdata`=0000 each with `rvalid`.
- Write 0:aaaa, 2:5678, 4:b4b3, 6:cccc (`be`=11); read 0,2,4,6,1,5 → aaaa, 5678, b4b3, cccc, 0000, 0000, each one cycle after its request.
- Byte lanes: write 3:ffff, then 3:1200 with `be`=10 → read 3 returns 12ff; a write with `be`=00 leaves 12ff.
- `DEPTH`=12, `AW`=4: write 13:dead, then read 13 → 0000 with `rvalid`=1; read 12 → 0000; no array word changes.
- `rst` pulsed 5 cycles into clear, and again during an outstanding read: no `rvalid`, `rdata`=0, `ready` returns `DEPTH` cycles after release, previously written words read 0000.
- With `SRAM_BANK_PARITY_EN`: write 8:00ff with `err_inj`=1 → read 8 gives `rdata`=00ff and `perr`=1; rewrite with `err_inj`=0 → `perr`=0.
